// File: rtl/bg_collision_pkg.sv
// Shared types and defaults for the background/sprite edge statistics block.
// Optional hit flags are enabled with the BG_COLLISION_HIT_EN macro.
package bg_collision_pkg;

    localparam int         SPR_SIZE_DEFAULT   = 16;
    localparam int         COORD_W_DEFAULT    = 10;
    localparam logic [7:0] HIT_THRESH_DEFAULT = 8'h80;

    localparam int NUM_EDGES = 4;

    // Colour channel positions inside an rgb_t
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // Edge index; hit bits are ordered {top, bottom, right, left}
    typedef enum logic [1:0] {
        EDGE_TOP    = 2'd0,
        EDGE_BOTTOM = 2'd1,
        EDGE_RIGHT  = 2'd2,
        EDGE_LEFT   = 2'd3
    } edge_e;

    typedef logic [2:0][7:0] rgb_t;

    typedef struct packed {
        rgb_t max_v;
        rgb_t min_v;
        rgb_t avg_v;
    } rgb_stat_t;

endpackage

// File: rtl/bg_edge_stats.sv
// Per-edge accumulator: tracks which offsets of one sprite edge have been
// sampled and latches max/min/avg of R, G, B once every offset is seen.
// With BG_COLLISION_HIT_EN defined, also registers a threshold hit flag.
module bg_edge_stats
    import bg_collision_pkg::*;
#(
    parameter int SPR_SIZE = SPR_SIZE_DEFAULT
`ifdef BG_COLLISION_HIT_EN
    , parameter logic [7:0] HIT_THRESH = HIT_THRESH_DEFAULT
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        on_edge_i,
    input  logic [$clog2(SPR_SIZE)-1:0] offset_i,
    input  logic [7:0]                  r_i,
    input  logic [7:0]                  g_i,
    input  logic [7:0]                  b_i,
    output rgb_stat_t                   stat_o
`ifdef BG_COLLISION_HIT_EN
    , output logic                      hit_o
`endif
);

    localparam int OFF_W = $clog2(SPR_SIZE);
    localparam int SUM_W = 8 + OFF_W;

    typedef logic [2:0][SUM_W-1:0] sum_t;

    logic [SPR_SIZE-1:0] seen_q, seen_d;
    rgb_t                max_q, max_d;
    rgb_t                min_q, min_d;
    rgb_t                avg_d;
    rgb_t                pix;
    sum_t                sum_q, sum_d;
    rgb_stat_t           stat_q;
    logic                first;
    logic                accept;
    logic                complete;

    // Next-state of the accumulators assuming the current pixel is accepted
    always_comb begin
        pix      = {b_i, g_i, r_i};
        first    = (seen_q == '0);
        accept   = on_edge_i && !seen_q[offset_i];
        seen_d   = seen_q | (SPR_SIZE'(1) << offset_i);
        complete = accept && (&seen_d);
        for (int c = 0; c < 3; c++) begin
            max_d[c] = (first || (pix[c] > max_q[c])) ? pix[c] : max_q[c];
            min_d[c] = (first || (pix[c] < min_q[c])) ? pix[c] : min_q[c];
            sum_d[c] = sum_q[c] + SUM_W'(pix[c]);
            avg_d[c] = 8'(sum_d[c] >> OFF_W);
        end
    end

    // Accept new offsets; on the last one latch results and restart the pass
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            seen_q <= '0;
            max_q  <= '0;
            min_q  <= '1;
            sum_q  <= '0;
            stat_q <= '0;
        end else if (accept) begin
            if (complete) begin
                stat_q <= '{max_v: max_d, min_v: min_d, avg_v: avg_d};
                seen_q <= '0;
                max_q  <= '0;
                min_q  <= '1;
                sum_q  <= '0;
            end else begin
                seen_q <= seen_d;
                max_q  <= max_d;
                min_q  <= min_d;
                sum_q  <= sum_d;
            end
        end
    end

    assign stat_o = stat_q;

`ifdef BG_COLLISION_HIT_EN
    logic hit_q;

    // Hit flag refreshed at each completion from the final channel maxima
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
        end else if (complete) begin
            hit_q <= (max_d[CH_R] >= HIT_THRESH) ||
                     (max_d[CH_G] >= HIT_THRESH) ||
                     (max_d[CH_B] >= HIT_THRESH);
        end
    end

    assign hit_o = hit_q;
`endif

endmodule

// File: rtl/background_collision.sv
// Decodes which sprite-box edge the current background pixel lies on and fans
// the four per-edge statistics out to flat ports.
// Optional hit output is enabled with the BG_COLLISION_HIT_EN macro.
module background_collision
    import bg_collision_pkg::*;
#(
    parameter int SPR_SIZE = SPR_SIZE_DEFAULT,
    parameter int COORD_W  = COORD_W_DEFAULT
`ifdef BG_COLLISION_HIT_EN
    , parameter logic [7:0] HIT_THRESH = HIT_THRESH_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         R_bg,
    input  logic [7:0]         G_bg,
    input  logic [7:0]         B_bg,
    input  logic [COORD_W-1:0] ancora_bg_X,
    input  logic [COORD_W-1:0] ancora_bg_Y,
    input  logic [COORD_W-1:0] ancora_sp_X,
    input  logic [COORD_W-1:0] ancora_sp_Y,
    output logic [7:0] max_R_top, max_G_top, max_B_top,
    output logic [7:0] max_R_bottom, max_G_bottom, max_B_bottom,
    output logic [7:0] max_R_right, max_G_right, max_B_right,
    output logic [7:0] max_R_left, max_G_left, max_B_left,
    output logic [7:0] min_R_top, min_G_top, min_B_top,
    output logic [7:0] min_R_bottom, min_G_bottom, min_B_bottom,
    output logic [7:0] min_R_right, min_G_right, min_B_right,
    output logic [7:0] min_R_left, min_G_left, min_B_left,
    output logic [7:0] avg_R_top, avg_G_top, avg_B_top,
    output logic [7:0] avg_R_bottom, avg_G_bottom, avg_B_bottom,
    output logic [7:0] avg_R_right, avg_G_right, avg_B_right,
    output logic [7:0] avg_R_left, avg_G_left, avg_B_left
`ifdef BG_COLLISION_HIT_EN
    , output logic [3:0] hit
`endif
);

    localparam int OFF_W = $clog2(SPR_SIZE);
    localparam int EXT_W = COORD_W + 1;

    logic [1:0]           rst_sync_q;
    logic                 rst_n_int;
    logic [EXT_W-1:0]     x_ext, y_ext, spx, spy, spx_end, spy_end;
    logic                 in_x, in_y;
    logic [NUM_EDGES-1:0] on_edge;
    logic [OFF_W-1:0]     off_x, off_y;
    rgb_stat_t            stats [NUM_EDGES];

    // Reset release synchroniser: assert asynchronously, release on clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Edge membership; one extra bit keeps a box past the raster from wrapping
    always_comb begin
        x_ext   = {1'b0, ancora_bg_X};
        y_ext   = {1'b0, ancora_bg_Y};
        spx     = {1'b0, ancora_sp_X};
        spy     = {1'b0, ancora_sp_Y};
        spx_end = spx + EXT_W'(SPR_SIZE - 1);
        spy_end = spy + EXT_W'(SPR_SIZE - 1);
        in_x    = (x_ext >= spx) && (x_ext <= spx_end);
        in_y    = (y_ext >= spy) && (y_ext <= spy_end);
        off_x   = OFF_W'(ancora_bg_X - ancora_sp_X);
        off_y   = OFF_W'(ancora_bg_Y - ancora_sp_Y);
        on_edge              = '0;
        on_edge[EDGE_TOP]    = (y_ext == spy)     && in_x;
        on_edge[EDGE_BOTTOM] = (y_ext == spy_end) && in_x;
        on_edge[EDGE_RIGHT]  = (x_ext == spx_end) && in_y;
        on_edge[EDGE_LEFT]   = (x_ext == spx)     && in_y;
    end

    for (genvar e = 0; e < NUM_EDGES; e++) begin : g_edge
        localparam edge_e EDGE = edge_e'(e);

        bg_edge_stats #(
            .SPR_SIZE  (SPR_SIZE)
`ifdef BG_COLLISION_HIT_EN
            , .HIT_THRESH(HIT_THRESH)
`endif
        ) u_stats (
            .clk      (clk),
            .rst_n    (rst_n_int),
            .on_edge_i(on_edge[e]),
            .offset_i ((EDGE == EDGE_TOP || EDGE == EDGE_BOTTOM) ? off_x : off_y),
            .r_i      (R_bg),
            .g_i      (G_bg),
            .b_i      (B_bg),
            .stat_o   (stats[e])
`ifdef BG_COLLISION_HIT_EN
            , .hit_o  (hit[NUM_EDGES-1-e])
`endif
        );
    end

    assign max_R_top    = stats[EDGE_TOP].max_v[CH_R];
    assign max_G_top    = stats[EDGE_TOP].max_v[CH_G];
    assign max_B_top    = stats[EDGE_TOP].max_v[CH_B];
    assign min_R_top    = stats[EDGE_TOP].min_v[CH_R];
    assign min_G_top    = stats[EDGE_TOP].min_v[CH_G];
    assign min_B_top    = stats[EDGE_TOP].min_v[CH_B];
    assign avg_R_top    = stats[EDGE_TOP].avg_v[CH_R];
    assign avg_G_top    = stats[EDGE_TOP].avg_v[CH_G];
    assign avg_B_top    = stats[EDGE_TOP].avg_v[CH_B];

    assign max_R_bottom = stats[EDGE_BOTTOM].max_v[CH_R];
    assign max_G_bottom = stats[EDGE_BOTTOM].max_v[CH_G];
    assign max_B_bottom = stats[EDGE_BOTTOM].max_v[CH_B];
    assign min_R_bottom = stats[EDGE_BOTTOM].min_v[CH_R];
    assign min_G_bottom = stats[EDGE_BOTTOM].min_v[CH_G];
    assign min_B_bottom = stats[EDGE_BOTTOM].min_v[CH_B];
    assign avg_R_bottom = stats[EDGE_BOTTOM].avg_v[CH_R];
    assign avg_G_bottom = stats[EDGE_BOTTOM].avg_v[CH_G];
    assign avg_B_bottom = stats[EDGE_BOTTOM].avg_v[CH_B];

    assign max_R_right  = stats[EDGE_RIGHT].max_v[CH_R];
    assign max_G_right  = stats[EDGE_RIGHT].max_v[CH_G];
    assign max_B_right  = stats[EDGE_RIGHT].max_v[CH_B];
    assign min_R_right  = stats[EDGE_RIGHT].min_v[CH_R];
    assign min_G_right  = stats[EDGE_RIGHT].min_v[CH_G];
    assign min_B_right  = stats[EDGE_RIGHT].min_v[CH_B];
    assign avg_R_right  = stats[EDGE_RIGHT].avg_v[CH_R];
    assign avg_G_right  = stats[EDGE_RIGHT].avg_v[CH_G];
    assign avg_B_right  = stats[EDGE_RIGHT].avg_v[CH_B];

    assign max_R_left   = stats[EDGE_LEFT].max_v[CH_R];
    assign max_G_left   = stats[EDGE_LEFT].max_v[CH_G];
    assign max_B_left   = stats[EDGE_LEFT].max_v[CH_B];
    assign min_R_left   = stats[EDGE_LEFT].min_v[CH_R];
    assign min_G_left   = stats[EDGE_LEFT].min_v[CH_G];
    assign min_B_left   = stats[EDGE_LEFT].min_v[CH_B];
    assign avg_R_left   = stats[EDGE_LEFT].avg_v[CH_R];
    assign avg_G_left   = stats[EDGE_LEFT].avg_v[CH_G];
    assign avg_B_left   = stats[EDGE_LEFT].avg_v[CH_B];

endmodule

// File: tb/tb_background_collision.sv
// Directed bench for background_collision: sprite-edge statistics passes,
// duplicate/out-of-box rejection, reset behaviour and raster-edge boundary.
module tb_background_collision;

    localparam int E_TOP = 0;
    localparam int E_BOT = 1;
    localparam int E_RGT = 2;
    localparam int E_LFT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] R_bg, G_bg, B_bg;
    logic [9:0] ancora_bg_X, ancora_bg_Y, ancora_sp_X, ancora_sp_Y;
    logic [7:0] max_R_top, max_G_top, max_B_top;
    logic [7:0] max_R_bottom, max_G_bottom, max_B_bottom;
    logic [7:0] max_R_right, max_G_right, max_B_right;
    logic [7:0] max_R_left, max_G_left, max_B_left;
    logic [7:0] min_R_top, min_G_top, min_B_top;
    logic [7:0] min_R_bottom, min_G_bottom, min_B_bottom;
    logic [7:0] min_R_right, min_G_right, min_B_right;
    logic [7:0] min_R_left, min_G_left, min_B_left;
    logic [7:0] avg_R_top, avg_G_top, avg_B_top;
    logic [7:0] avg_R_bottom, avg_G_bottom, avg_B_bottom;
    logic [7:0] avg_R_right, avg_G_right, avg_B_right;
    logic [7:0] avg_R_left, avg_G_left, avg_B_left;
`ifdef BG_COLLISION_HIT_EN
    logic [3:0] hit;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    background_collision dut (
        .clk(clk), .rst(rst),
        .R_bg(R_bg), .G_bg(G_bg), .B_bg(B_bg),
        .ancora_bg_X(ancora_bg_X), .ancora_bg_Y(ancora_bg_Y),
        .ancora_sp_X(ancora_sp_X), .ancora_sp_Y(ancora_sp_Y),
        .max_R_top(max_R_top), .max_G_top(max_G_top), .max_B_top(max_B_top),
        .max_R_bottom(max_R_bottom), .max_G_bottom(max_G_bottom), .max_B_bottom(max_B_bottom),
        .max_R_right(max_R_right), .max_G_right(max_G_right), .max_B_right(max_B_right),
        .max_R_left(max_R_left), .max_G_left(max_G_left), .max_B_left(max_B_left),
        .min_R_top(min_R_top), .min_G_top(min_G_top), .min_B_top(min_B_top),
        .min_R_bottom(min_R_bottom), .min_G_bottom(min_G_bottom), .min_B_bottom(min_B_bottom),
        .min_R_right(min_R_right), .min_G_right(min_G_right), .min_B_right(min_B_right),
        .min_R_left(min_R_left), .min_G_left(min_G_left), .min_B_left(min_B_left),
        .avg_R_top(avg_R_top), .avg_G_top(avg_G_top), .avg_B_top(avg_B_top),
        .avg_R_bottom(avg_R_bottom), .avg_G_bottom(avg_G_bottom), .avg_B_bottom(avg_B_bottom),
        .avg_R_right(avg_R_right), .avg_G_right(avg_G_right), .avg_B_right(avg_B_right),
        .avg_R_left(avg_R_left), .avg_G_left(avg_G_left), .avg_B_left(avg_B_left)
`ifdef BG_COLLISION_HIT_EN
        , .hit(hit)
`endif
    );

    // Per-edge views of the flat ports, channel index 0 = R, 1 = G, 2 = B
    logic [2:0][7:0] mx [4];
    logic [2:0][7:0] mn [4];
    logic [2:0][7:0] av [4];

    assign mx[E_TOP] = {max_B_top, max_G_top, max_R_top};
    assign mn[E_TOP] = {min_B_top, min_G_top, min_R_top};
    assign av[E_TOP] = {avg_B_top, avg_G_top, avg_R_top};
    assign mx[E_BOT] = {max_B_bottom, max_G_bottom, max_R_bottom};
    assign mn[E_BOT] = {min_B_bottom, min_G_bottom, min_R_bottom};
    assign av[E_BOT] = {avg_B_bottom, avg_G_bottom, avg_R_bottom};
    assign mx[E_RGT] = {max_B_right, max_G_right, max_R_right};
    assign mn[E_RGT] = {min_B_right, min_G_right, min_R_right};
    assign av[E_RGT] = {avg_B_right, avg_G_right, avg_R_right};
    assign mx[E_LFT] = {max_B_left, max_G_left, max_R_left};
    assign mn[E_LFT] = {min_B_left, min_G_left, min_R_left};
    assign av[E_LFT] = {avg_B_left, avg_G_left, avg_R_left};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Same expected max/min/avg on all three channels of one edge
    task automatic check_edge(input string tag, input int e,
                              input logic [7:0] mxe, input logic [7:0] mne,
                              input logic [7:0] ave);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s.max[%0d]", tag, c), mx[e][c], mxe);
            check($sformatf("%s.min[%0d]", tag, c), mn[e][c], mne);
            check($sformatf("%s.avg[%0d]", tag, c), av[e][c], ave);
        end
    endtask

    // Present one pixel for n cycles, then park the coordinate off every edge
    task automatic px_rgb(input int x, input int y, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b, input int n);
        ancora_bg_X = 10'(x);
        ancora_bg_Y = 10'(y);
        R_bg = r;
        G_bg = g;
        B_bg = b;
        repeat (n) @(posedge clk);
        #1;
        ancora_bg_X = 10'd1023;
        ancora_bg_Y = 10'd1023;
    endtask

    task automatic px(input int x, input int y, input logic [7:0] v, input int n);
        px_rgb(x, y, v, v, v, n);
    endtask

    task automatic set_sp(input int x, input int y);
        ancora_sp_X = 10'(x);
        ancora_sp_Y = 10'(y);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with arbitrary inputs
        rst = 1'b0;
        set_sp(5, 5);
        ancora_bg_X = 10'd5;
        ancora_bg_Y = 10'd5;
        R_bg = 8'hAA; G_bg = 8'h55; B_bg = 8'hC3;
        repeat (3) @(posedge clk);
        #1;
        for (int e = 0; e < 4; e++) check_edge($sformatf("reset.e%0d", e), e, 0, 0, 0);
`ifdef BG_COLLISION_HIT_EN
        check("reset.hit", {4'b0, hit}, 8'h00);
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single pixel: pass incomplete, outputs stay zero
        px(5, 5, 8'd1, 1);
        check_edge("single.top", E_TOP, 0, 0, 0);
        check_edge("single.left", E_LFT, 0, 0, 0);
        do_reset();

        // Top pass, value = x - 5
        for (int x = 5; x <= 20; x++) px(x, 5, 8'(x - 5), 1);
        check_edge("top1", E_TOP, 15, 0, 7);
        check_edge("top1.left", E_LFT, 0, 0, 0);
        check_edge("top1.right", E_RGT, 0, 0, 0);

        // Same pass with every coordinate held three cycles
        for (int x = 5; x <= 20; x++) px(x, 5, 8'(x - 5), 3);
        check_edge("top_hold3", E_TOP, 15, 0, 7);

        // Already-accepted offset re-presented with a different colour
        for (int x = 5; x <= 10; x++) px(x, 5, 8'(x - 5), 1);
        px(10, 5, 8'hFF, 4);
        check_edge("top_dup_mid", E_TOP, 15, 0, 7);
        for (int x = 11; x <= 20; x++) px(x, 5, 8'(x - 5), 1);
        check_edge("top_dup", E_TOP, 15, 0, 7);

        // Left pass: 7 everywhere except 31 at y = 10
        do_reset();
        for (int y = 5; y <= 20; y++) px(5, y, (y == 10) ? 8'd31 : 8'd7, 1);
        check_edge("left", E_LFT, 31, 7, 8);
        check_edge("left.top", E_TOP, 0, 0, 0);

        // Left pass with out-of-box pixels interleaved
        do_reset();
        for (int y = 5; y <= 12; y++) px(5, y, (y == 10) ? 8'd31 : 8'd7, 1);
        px(5, 25, 8'hFF, 2);
        px(5, 1, 8'h00, 2);
        px(5, 4, 8'h00, 1);
        px(5, 21, 8'hFF, 1);
        for (int y = 13; y <= 20; y++) px(5, y, 8'd7, 1);
        check_edge("oob_left", E_LFT, 31, 7, 8);

        // Reset in the middle of a pass
        for (int x = 5; x <= 12; x++) px(x, 5, 8'd200, 1);
        rst = 1'b0;
        #2;
        check_edge("midrst.left", E_LFT, 0, 0, 0);
        check_edge("midrst.top", E_TOP, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int x = 5; x <= 20; x++) px(x, 5, 8'd3, 1);
        check_edge("top_after_rst", E_TOP, 3, 3, 3);

        // Bottom pass with distinct channel patterns
        set_sp(100, 200);
        for (int x = 100; x <= 115; x++)
            px_rgb(x, 215, 8'((x - 100) * 16), 8'(255 - (x - 100) * 16), 8'd9, 1);
        check("bot.maxR", max_R_bottom, 8'd240);
        check("bot.minR", min_R_bottom, 8'd0);
        check("bot.avgR", avg_R_bottom, 8'd120);
        check("bot.maxG", max_G_bottom, 8'd255);
        check("bot.minG", min_G_bottom, 8'd15);
        check("bot.avgG", avg_G_bottom, 8'd135);
        check("bot.maxB", max_B_bottom, 8'd9);
        check("bot.minB", min_B_bottom, 8'd9);
        check("bot.avgB", avg_B_bottom, 8'd9);
        check_edge("bot.top_held", E_TOP, 3, 3, 3);

        // Box past the raster edge: right edge x = 1035 must not alias to 11
        set_sp(1020, 100);
        for (int y = 100; y <= 115; y++) px(11, y, 8'd50, 1);
        check_edge("wrap.right", E_RGT, 0, 0, 0);

`ifdef BG_COLLISION_HIT_EN
        // One pixel at the threshold on the top edge
        do_reset();
        set_sp(5, 5);
        for (int x = 5; x <= 20; x++) px(x, 5, (x == 12) ? 8'h80 : 8'h00, 1);
        check("hit", {4'b0, hit}, 8'b0000_1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/background_collision.md
Name: background_collision

Overview:
- Samples a background pixel stream against a square sprite bounding box and gathers per-edge colour statistics for the collision/merge logic.
- For each of the four edge lines of the sprite box (top, bottom, right, left), it computes max, min and average of R, G and B over the background pixels under that edge.
- Sits in modulo_merge, between the background pixel source and the sprite/background merge and collision decision logic.

Parameters:
- SPR_SIZE, 16: sprite width = height in pixels. Must be a power of two; the average is computed as sum >> log2(SPR_SIZE).
- COORD_W, 10: coordinate width.
- HIT_THRESH, 8'h80: threshold used only by the optional feature.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- R_bg / G_bg / B_bg, input, 8 each: background pixel colour at the current coordinate.
- ancora_bg_X / ancora_bg_Y, input, COORD_W each: coordinate of the current background pixel.
- ancora_sp_X / ancora_sp_Y, input, COORD_W each: sprite top-left anchor.
- max_{R,G,B}_{top,bottom,right,left}, output, 8 each (12 ports): latched per-edge channel maximum.
- min_{R,G,B}_{top,bottom,right,left}, output, 8 each (12 ports): latched per-edge channel minimum.
- avg_{R,G,B}_{top,bottom,right,left}, output, 8 each (12 ports): latched per-edge channel average.

Behaviour:
- Edge definitions, with E = SPR_SIZE-1 and sums computed in COORD_W+1 bits so a box running past 2^COORD_W-1 never wraps and matches nothing:
  - top: y == sp_Y and sp_X <= x <= sp_X+E; offset = x - sp_X.
  - bottom: y == sp_Y+E with the same x range; offset = x - sp_X.
  - left: x == sp_X and sp_Y <= y <= sp_Y+E; offset = y - sp_Y.
  - right: x == sp_X+E with the same y range; offset = y - sp_Y.
- A corner pixel belongs to two edges and is accumulated in both.
- Pixels outside all edges (including interior pixels and e.g. y = sp_Y-1 or y > sp_Y+E) are ignored.
- Per-edge state (4 independent instances):
  - seen mask, SPR_SIZE bits;
  - running max, 8 bits per channel;
  - running min, 8 bits per channel;
  - running sum, 8+log2(SPR_SIZE) bits per channel.
- Sample acceptance: on a rising edge, if the pixel lies on the edge and seen[offset] == 0, then:
  - set seen[offset];
  - update max and min;
  - add the pixel to the sum.
- A coordinate held for several cycles counts once per pass. A repeated offset whose mask bit is already set is ignored even if its colour changed.
- Completion: on the edge where the accepted sample makes the mask all-ones, in that same clock edge:
  - outputs load max, min and (sum + sample) >> log2(SPR_SIZE), with the final sample included;
  - the mask clears, max resets to 0, min resets to 8'hFF, sum resets to 0.
- Outputs therefore become visible after the clock edge accepting the last distinct pixel. They are held until the next completion.
- The first sample of a pass initialises max and min directly, so a single-valued pass gives max = min = that value.
- Moving ancora_sp_* mid-pass does not clear accumulators. Offsets are recomputed against the new anchor.
- Reset (rst = 0, asynchronous):
  - all 36 outputs go to 0;
  - masks clear, running max = 0, running min = 8'hFF, sums = 0.
- Deassertion of reset is synchronised by the usual two-flop release; no stat update happens during reset.
- Arithmetic is unsigned throughout. Sums cannot overflow: worst case 16 × 255 = 4080 fits in 12 bits.

Optional Feature:
- Macro: BG_COLLISION_HIT_EN.
- When defined:
  - adds output hit, 4 bits {top, bottom, right, left};
  - reset value 0;
  - a bit is registered at each completion of that edge, set iff the latched max of any channel on that edge >= HIT_THRESH.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bg_collision_pkg holds:
  - SPR_SIZE and COORD_W defaults;
  - the edge index enum (TOP, BOTTOM, RIGHT, LEFT);
  - the RGB stat struct type (max, min, avg per channel).
- Sub-module bg_edge_stats, instantiated 4 times, holds:
  - inputs: on_edge, offset, R, G, B;
  - the mask, accumulators and completion latch;
  - the stat outputs.
- The top level does only the coordinate/edge decode and output fan-out.

Test Plan:
- Reset: hold rst = 0 with arbitrary inputs → all 36 outputs = 0. Release, apply sp = (5,5), bg = (5,5), RGB = 1 for one cycle → outputs remain 0 (pass incomplete).
- Top pass: sp = (5,5); feed y = 5, x = 5..20 with R = G = B = x-5 → after x = 20: max_*_top = 15, min_*_top = 0, avg_*_top = 7 (120 >> 4). The left edge is not complete, so left outputs stay 0.
- Duplicates:
  - repeat the top pass, holding each coordinate 3 cycles → identical results;
  - hold x = 10 with value 8'hFF after it was already accepted → no effect.
- Left pass: feed x = 5, y = 5..20, RGB = 7 except y = 10 with RGB = 31 → max_left = 31, min_left = 7, avg_left = (15·7 + 31) >> 4 = 8.
- Out-of-box: feed (5,25) RGB = FF and (5,1) RGB = 00 amid a left pass → ignored; results as in the left-pass case.
- Reset mid-pass: accept 8 top pixels, assert rst, release, then run a full top pass with RGB = 3 → max = min = avg = 3. With BG_COLLISION_HIT_EN: a top pass with one pixel 8'h80 → hit = 4'b1000.
